hazard_scoreboard: RTL and testbench

Issue-side hazard controller for the 5-stage MIPS pipeline. Runs opposite the EXE-stage forwarding selector: it tracks every destination register issued from ID as the instruction moves through EXE, MEM and WB. It stalls ID when an operand cannot yet be forwarded, and freezes EXE while a multi-cycle mul/div occupies it. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_scoreboard.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Issue-side hazard controller for the 5-stage MIPS pipeline.
//            Tracks destinations issued from ID through EXE/MEM/WB, stalls ID
//            when an operand is not yet available, freezes EXE while a
//            multi-cycle mul/div runs, and counts stall cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   HAZARD_FORWARDING_EN  defined   -> only load-use stalls (EXE forwarding)
//                         undefined -> any EXE/MEM write-back dependency stalls
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W        register address width
//   MULDIV_CYCLES cycles a mul/div occupies EXE (>=1, 1 = single cycle)
//   CNT_W         stall counter width
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs, id_rt             source register numbers
//   id_uses_rs, id_uses_rt   source is actually read
//   id_wb_en, id_dest        instruction writes id_dest
//   id_mem_read              instruction is a load
//   id_multicycle            instruction is a mul/div
//   flush                    kill the ID instruction
//   stall                    hold PC and IF/ID
//   id_ex_bubble             load a NOP into ID/EX
//   ex_hold                  freeze ID/EX, bubble into EX/MEM
//   md_busy                  multi-cycle op still counting
//   stall_cnt                saturating count of stall cycles
// ============================================================================
module hazard_scoreboard #(
    parameter int ADDR_W        = 5,
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wb_en,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_mem_read,
    input  logic              id_multicycle,
    input  logic              flush,
    output logic              stall,
    output logic              id_ex_bubble,
    output logic              ex_hold,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // md_cnt only ever holds values 1..MULDIV_CYCLES-1
    localparam int                 c_MD_W    = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [c_MD_W-1:0]  c_MD_LOAD = c_MD_W'(MULDIV_CYCLES - 1);
    localparam logic [c_MD_W-1:0]  c_MD_ONE  = c_MD_W'(1);
    localparam logic               c_MULTI   = (MULDIV_CYCLES > 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_MD_W-1:0]   r_md_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;

    // Pipeline slots
    logic                r_exe_valid, r_exe_wb_en, r_exe_mem_read;
    logic [ADDR_W-1:0]   r_exe_dest;
    logic                r_mem_valid, r_mem_wb_en, r_mem_mem_read;
    logic [ADDR_W-1:0]   r_mem_dest;
    logic                r_wb_valid, r_wb_wb_en, r_wb_mem_read;
    logic [ADDR_W-1:0]   r_wb_dest;

    logic                w_id_live;
    logic                w_exe_match;
    logic                w_hz;
    logic                w_stall;
    logic                w_issue;
    logic                w_unused_wb;

    assign w_id_live = id_valid & ~flush;

    assign w_exe_match = r_exe_valid & r_exe_wb_en & (r_exe_dest != '0) &
                         ((id_uses_rs & (r_exe_dest == id_rs)) |
                          (id_uses_rt & (r_exe_dest == id_rt)));

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers everything except a load whose data is still in MEM
    assign w_hz = w_id_live & w_exe_match & r_exe_mem_read;
`else
    logic w_mem_match;
    assign w_mem_match = r_mem_valid & r_mem_wb_en & (r_mem_dest != '0) &
                         ((id_uses_rs & (r_mem_dest == id_rs)) |
                          (id_uses_rt & (r_mem_dest == id_rt)));
    // WB is excluded: the register file writes through to the ID read
    assign w_hz = w_id_live & (w_exe_match | w_mem_match);
`endif

    assign md_busy      = (r_state == S_BUSY);
    assign ex_hold      = md_busy;
    assign w_stall      = md_busy | w_hz;
    assign stall        = w_stall;
    // A frozen EXE must not be overwritten by a bubble
    assign id_ex_bubble = w_hz & ~md_busy;
    assign stall_cnt    = r_stall_cnt;

    assign w_issue = w_id_live & ~w_stall;

    // WB slot is the retirement point; nothing downstream consumes it
    assign w_unused_wb = ^{r_wb_valid, r_wb_wb_en, r_wb_dest, r_wb_mem_read};

    // ------------------------------------------------------------------
    // Slot pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe_valid    <= 1'b0;
            r_exe_wb_en    <= 1'b0;
            r_exe_dest     <= '0;
            r_exe_mem_read <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_wb_en    <= 1'b0;
            r_mem_dest     <= '0;
            r_mem_mem_read <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_wb_en     <= 1'b0;
            r_wb_dest      <= '0;
            r_wb_mem_read  <= 1'b0;
        end else begin
            if (ex_hold) begin
                // EXE keeps its op; a bubble enters MEM behind it
                r_mem_valid    <= 1'b0;
                r_mem_wb_en    <= 1'b0;
                r_mem_dest     <= '0;
                r_mem_mem_read <= 1'b0;
            end else begin
                r_exe_valid    <= w_issue;
                r_exe_wb_en    <= w_issue & id_wb_en;
                r_exe_dest     <= w_issue ? id_dest : '0;
                r_exe_mem_read <= w_issue & id_mem_read;
                r_mem_valid    <= r_exe_valid;
                r_mem_wb_en    <= r_exe_wb_en;
                r_mem_dest     <= r_exe_dest;
                r_mem_mem_read <= r_exe_mem_read;
            end
            r_wb_valid    <= r_mem_valid;
            r_wb_wb_en    <= r_mem_wb_en;
            r_wb_dest     <= r_mem_dest;
            r_wb_mem_read <= r_mem_mem_read;
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_md_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue & id_multicycle & c_MULTI) begin
                        r_state  <= S_BUSY;
                        r_md_cnt <= c_MD_LOAD;
                    end
                end
                S_BUSY: begin
                    r_md_cnt <= r_md_cnt - c_MD_ONE;
                    if (r_md_cnt == c_MD_ONE) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_md_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed scoreboard bench for hazard_scoreboard. Expected output
//            sets are queued when a step is driven and compared at the
//            following falling edge. Follows HAZARD_FORWARDING_EN like the RTL.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs, id_rt, id_dest;
    logic              id_uses_rs, id_uses_rt, id_wb_en, id_mem_read, id_multicycle, flush;
    logic              stall, id_ex_bubble, ex_hold, md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    int                n_vec = 0;
    int                n_err = 0;
    logic [CNT_W-1:0]  e_cnt = '0;

    typedef struct {
        logic             stall;
        logic             bub;
        logic             hold;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];

    hazard_scoreboard #(
        .ADDR_W        (ADDR_W),
        .MULDIV_CYCLES (4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_wb_en      (id_wb_en),
        .id_dest       (id_dest),
        .id_mem_read   (id_mem_read),
        .id_multicycle (id_multicycle),
        .flush         (flush),
        .stall         (stall),
        .id_ex_bubble  (id_ex_bubble),
        .ex_hold       (ex_hold),
        .md_busy       (md_busy),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wb,
                         input logic [4:0] dst, input logic mr, input logic mc,
                         input logic fl);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_wb_en      = wb;
        id_dest       = dst;
        id_mem_read   = mr;
        id_multicycle = mc;
        flush         = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue expectations for the current cycle, compare at negedge,
    // then move to just after the next rising edge.
    task automatic step(input string tag, input logic es, input logic eb,
                        input logic eh, input logic ebz);
        exp_t e;
        e.stall = es;
        e.bub   = eb;
        e.hold  = eh;
        e.busy  = ebz;
        e.cnt   = e_cnt;
        q.push_back(e);
        if (es) e_cnt = (e_cnt == '1) ? e_cnt : e_cnt + 1'b1;
        if (rst) e_cnt = '0;
        @(negedge clk);
        e = q.pop_front();
        chk({tag, ".stall"},     8'(stall),        8'(e.stall));
        chk({tag, ".bubble"},    8'(id_ex_bubble), 8'(e.bub));
        chk({tag, ".ex_hold"},   8'(ex_hold),      8'(e.hold));
        chk({tag, ".md_busy"},   8'(md_busy),      8'(e.busy));
        chk({tag, ".stall_cnt"}, 8'(stall_cnt),    8'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        step("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use: lw r5 ; add r6,r5,r7
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step("lu_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        step("lu_c1", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_FORWARDING_EN
        step("lu_c2", 1'b0, 1'b0, 1'b0, 1'b0);
`else
        step("lu_c2", 1'b1, 1'b1, 1'b0, 1'b0);
        step("lu_c3", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        chk("lu_issue.valid", 8'(dut.r_exe_valid), 8'd1);
        chk("lu_issue.dest",  8'(dut.r_exe_dest),  8'd6);
        nop();
        repeat (3) step("lu_drain", 1'b0, 1'b0, 1'b0, 1'b0);

        // Destination r0: lw r0 ; add r1,r0,r0
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        step("r0_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        step("r0_c1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r0_issue.dest", 8'(dut.r_exe_dest), 8'd1);
        nop();
        repeat (3) step("r0_drain", 1'b0, 1'b0, 1'b0, 1'b0);

        // Multi-cycle: mul r8 ; add r9,r8,r8 waiting in ID
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
        step("mul_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step("mul_c1", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mul_c2.mem_valid", 8'(dut.r_mem_valid), 8'd0);
        step("mul_c2", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mul_c3.mem_valid", 8'(dut.r_mem_valid), 8'd0);
        step("mul_c3", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mul_c4.mem_valid", 8'(dut.r_mem_valid), 8'd0);
        chk("mul_c4.exe_dest",  8'(dut.r_exe_dest),  8'd8);
`ifdef HAZARD_FORWARDING_EN
        step("mul_c4", 1'b0, 1'b0, 1'b0, 1'b0);
`else
        step("mul_c4", 1'b1, 1'b1, 1'b0, 1'b0);
        step("mul_c5", 1'b1, 1'b1, 1'b0, 1'b0);
        step("mul_c6", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        chk("mul_dep.exe_dest", 8'(dut.r_exe_dest), 8'd9);
        nop();
        repeat (3) step("mul_drain", 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush during hazard: lw r5 ; dependent op flushed
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step("fl_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
        step("fl_c1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fl_c2.exe_valid", 8'(dut.r_exe_valid), 8'd0);
        nop();
        repeat (3) step("fl_drain", 1'b0, 1'b0, 1'b0, 1'b0);

        // Second mul with empty ID: drives the counter to saturation
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1, 1'b0);
        step("mul2_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        nop();
        repeat (3) step("mul2_busy", 1'b1, 1'b0, 1'b1, 1'b1);
        step("mul2_c4", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step("mul2_drain", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-BUSY
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
        step("rb_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step("rb_c1", 1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step("rb_c2", 1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        step("rb_c3", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rb_issue.valid", 8'(dut.r_exe_valid), 8'd1);
        chk("rb_issue.dest",  8'(dut.r_exe_dest),  8'd10);
        nop();
        step("rb_c4", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
